// File: rtl/cnn_inst_queue.sv
// rtl/cnn_inst_queue.sv - instruction FIFO and issue sequencer feeding the CNN instruction parser
module cnn_inst_queue #(
    parameter int INST_W = 128,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              CLOCK65,
    input  logic              RESETN,
    input  logic [INST_W-1:0] cnn_inst,
    input  logic              cnn_inst_en,
    input  logic              parser_ready,
    output logic [INST_W-1:0] parser_inst,
    output logic              parser_inst_en,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       inst_count,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_CMP,
        S_DONE
    } state_t;

    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [7:0]  L_CLEAR = 8'd1;
    localparam logic [7:0]  L_START = 8'd2;

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic [INST_W-1:0] r_parser_inst;
    logic              r_parser_inst_en;
    logic              r_done;
    state_t            r_state;

    logic w_upper_zero;
    logic w_clear;
    logic w_start;
    logic w_is_inst;
    logic w_push;
    logic w_pop;

    // Classify the host word: control words have all bits above the low byte clear
    always_comb begin
        w_upper_zero = (cnn_inst[INST_W-1:8] == '0);
        w_clear      = cnn_inst_en && w_upper_zero && (cnn_inst[7:0] == L_CLEAR);
        w_start      = cnn_inst_en && w_upper_zero && (cnn_inst[7:0] == L_START);
        w_is_inst    = cnn_inst_en && !w_upper_zero;
        w_push       = w_is_inst && (r_count < L_DEPTH);
        w_pop        = (r_state == S_ISSUE) && (r_count != '0) && parser_ready && !w_clear;
    end

    // FIFO storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge CLOCK65) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cnn_inst;
        end
    end

    // Pointers, occupancy, sticky overflow and the issue sequencer
    always_ff @(posedge CLOCK65) begin
        if (!RESETN) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_overflow       <= 1'b0;
            r_parser_inst    <= '0;
            r_parser_inst_en <= 1'b0;
            r_done           <= 1'b0;
            r_state          <= S_IDLE;
        end else begin
            r_parser_inst_en <= 1'b0;
            r_done           <= 1'b0;
            if (w_clear) begin
                // An op already handed to the parser is left to finish on its own
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_state    <= S_IDLE;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_is_inst && !w_push) begin
                    r_overflow <= 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (r_count == '0) begin
                            r_state <= S_DONE;
                        end else if (parser_ready) begin
                            r_parser_inst    <= r_mem[r_rd_ptr];
                            r_parser_inst_en <= 1'b1;
                            r_state          <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        // Wait for the parser to acknowledge by dropping ready
                        if (!parser_ready) begin
                            r_state <= S_WAIT_CMP;
                        end
                    end
                    S_WAIT_CMP: begin
                        if (parser_ready) begin
                            r_state <= S_ISSUE;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign parser_inst    = r_parser_inst;
    assign parser_inst_en = r_parser_inst_en;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign inst_count     = r_count;
    assign overflow       = r_overflow;

endmodule
